// File: rtl/gpu_char_writer.sv
// Read-modify-write of one char (16-bit) or pixel-block (8-bit) slot in 64-bit display memory.
// Define GPU_WRITER_CLEAR_EN to implement the clear command (op 2); otherwise op 2 is dropped.
module gpu_char_writer (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmdValid,
  output logic        cmdReady,
  input  logic [1:0]  cmdOp,
  input  logic [6:0]  cmdX,
  input  logic [5:0]  cmdY,
  input  logic [15:0] cmdData,
  output logic [10:0] memAddress,
  input  logic [63:0] memReadData,
  output logic [63:0] memWriteData,
  output logic        memWriteEnable,
  output logic        busy
);

`ifdef GPU_WRITER_CLEAR_EN
  typedef enum logic [2:0] {StIdle, StRead, StWait, StWrite, StClear} state_e;
  localparam logic [10:0] LastAddr = 11'd1199;
`else
  typedef enum logic [1:0] {StIdle, StRead, StWait, StWrite} state_e;
`endif

  state_e      state_q, state_d;
  logic [10:0] addr_q, addr_d;
  logic        pixel_q, pixel_d;
  logic [2:0]  slot_q, slot_d;
  logic [15:0] data_q, data_d;
  logic [63:0] rdata_q, rdata_d;
  logic        drop_q, drop_d;

  logic        accept, char_ok, pixel_ok;
  logic [10:0] char_addr, pixel_addr;
  logic [5:0]  shamt;
  logic [63:0] slot_mask, slot_bits;

  assign char_ok    = (cmdX <= 7'd79) && (cmdY <= 6'd29);
  assign pixel_ok   = (cmdX <= 7'd79) && (cmdY <= 6'd59);
  assign char_addr  = {5'd0, cmdY} * 11'd20 + {6'd0, cmdX[6:2]};
  assign pixel_addr = 11'd600 + {5'd0, cmdY} * 11'd10 + {7'd0, cmdX[6:3]};

  assign cmdReady   = (state_q == StIdle) && !reset;
  assign accept     = cmdValid && cmdReady;
  assign busy       = (state_q != StIdle);
  assign memAddress = addr_q;

  // Slot 0 is the most significant lane, so the shift distance counts down from the top.
  always_comb begin
    if (pixel_q) begin
      shamt     = {~slot_q, 3'b000};
      slot_mask = 64'hFF << shamt;
      slot_bits = {56'd0, data_q[7:0]} << shamt;
    end else begin
      shamt     = {~slot_q[1:0], 4'b0000};
      slot_mask = 64'hFFFF << shamt;
      slot_bits = {48'd0, data_q} << shamt;
    end
  end

  always_comb begin
    memWriteEnable = 1'b0;
    memWriteData   = '0;
    if (state_q == StWrite) begin
      memWriteEnable = 1'b1;
      memWriteData   = (rdata_q & ~slot_mask) | slot_bits;
    end
`ifdef GPU_WRITER_CLEAR_EN
    if (state_q == StClear) memWriteEnable = 1'b1;
`endif
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pixel_d = pixel_q;
    slot_d  = slot_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    drop_d  = drop_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          pixel_d = (cmdOp == 2'd1);
          slot_d  = (cmdOp == 2'd1) ? cmdX[2:0] : {1'b0, cmdX[1:0]};
          data_d  = cmdData;
          // Dropped commands spend one cycle in WAIT so busy still pulses once.
          drop_d  = 1'b1;
          state_d = StWait;
          case (cmdOp)
            2'd0: if (char_ok) begin
              addr_d  = char_addr;
              drop_d  = 1'b0;
              state_d = StRead;
            end
            2'd1: if (pixel_ok) begin
              addr_d  = pixel_addr;
              drop_d  = 1'b0;
              state_d = StRead;
            end
`ifdef GPU_WRITER_CLEAR_EN
            2'd2: begin
              addr_d  = '0;
              drop_d  = 1'b0;
              state_d = StClear;
            end
`endif
            default: ;
          endcase
        end
      end
      StRead:  state_d = StWait;
      StWait: begin
        rdata_d = memReadData;
        state_d = drop_q ? StIdle : StWrite;
      end
      StWrite: state_d = StIdle;
`ifdef GPU_WRITER_CLEAR_EN
      StClear: begin
        if (addr_q == LastAddr) state_d = StIdle;
        else                    addr_d  = addr_q + 11'd1;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      pixel_q <= 1'b0;
      slot_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pixel_q <= pixel_d;
      slot_q  <= slot_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      drop_q  <= drop_d;
    end
  end

endmodule
